mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter reg_width, default 12: data word width and core address width.
REQ-002 Parameter addr_width, default 12: width of mem_address; it is the low addr_width bits of the core address.
REQ-003 clk  input  1  single clock for all state; the shared data memory uses the same clock.
REQ-004 reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-005 req1 / req2  input  1  per-core access request; held high with stable operands until done.
REQ-006 wren1 / wren2  input  1  1 = write, 0 = read; qualifies req.
REQ-007 addr1 / addr2  input  reg_width  per-core word address.
REQ-008 wdata1 / wdata2  input  reg_width  per-core write data.
REQ-009 grant1 / grant2  output  1  core owns the memory port for the current transaction.
REQ-010 done1 / done2  output  1  one-cycle pulse; the transaction is complete.
REQ-011 rdata1 / rdata2  output  reg_width  last read result per core; held until that core's next read completes.
REQ-012 mem_address  output  addr_width  registered address to the shared memory.
REQ-013 mem_data  output  reg_width  registered write data to the shared memory.
REQ-014 mem_wren  output  1  registered write enable to the shared memory.
REQ-015 mem_q  input  reg_width  memory read data; valid the cycle after the edge that samples mem_address.
REQ-016 busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ACCESS, WAIT and DONE; all outputs are registered.
REQ-018 IDLE: if any req is high at an edge, select the owner, latch addr/wdata/wren into mem_address/mem_data/mem_wren, set the owner's grant, and go to ACCESS.
REQ-019 Single requester SHALL be granted at once; when both request, the core not served last SHALL win (round-robin).
REQ-020 The last-served pointer SHALL update only when a grant is issued.
REQ-021 ACCESS lasts exactly one cycle, in which memory samples the operands at its closing edge.
REQ-022 On leaving ACCESS, mem_wren SHALL return to 0; a write goes to DONE and a read goes to WAIT.
REQ-023 WAIT lasts one cycle; at its closing edge, load the owner's rdata from mem_q and go to DONE.
REQ-024 DONE lasts one cycle with the owner's done high; go to IDLE after it, clearing grant.
REQ-025 Requests SHALL be ignored in ACCESS, WAIT and DONE.
- A requester drops req at the edge ending DONE, so there is no double service.
REQ-026 Latency from req sampled to done high: write 2 cycles, read 3 cycles.
REQ-027 Throughput: one transaction per 3 (write) or 4 (read) cycles.
REQ-028 Operands SHALL be latched only in IDLE; later changes to addr/wdata/wren or a req drop are ignored, and the transaction completes with done pulsed.
REQ-029 mem_wren SHALL be high for exactly one cycle per write and never during a read.
REQ-030 The other core's grant, done and rdata SHALL be unaffected during a transaction.
REQ-031 Address bits above addr_width are discarded, with no wrap detection.
REQ-032 At most one grant and at most one done SHALL be high in any cycle.

Reset
REQ-033 On reset low, asynchronously force: state IDLE; grant1, grant2, done1, done2, mem_wren and busy to 0; mem_address, mem_data, rdata1 and rdata2 to 0; last-served to core2, so core1 wins the first tie.
REQ-034 Reset mid-transaction SHALL abort it with no done pulse and mem_wren dropped immediately; a write not yet sampled by memory is lost.
REQ-035 The first grant after reset release is possible at the first edge with reset high.

Verification
REQ-036 After reset, req1=1, wren1=1, addr1=0x005, wdata1=0xABC -> mem_wren high for one cycle with mem_address=0x05; done1 is 2 cycles after req sampled; memory[5]=0xABC.
REQ-037 Then req2=1, wren2=0, addr2=0x005 -> done2 pulses 3 cycles after req sampled, rdata2=0xABC, rdata1 unchanged, grant1 stays 0.
REQ-038 req1 and req2 rise in the same cycle after reset, both holding -> order is core1, core2, core1, core2, and never two grants at once.
REQ-039 During a core1 read (ACCESS), change addr1 and drop req1 -> the original address is used and done1 still pulses once.
REQ-040 Assert reset during ACCESS of a write to addr 0x010 -> mem_wren falls immediately, no done, all outputs 0, and memory[0x10] is unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-core round-robin arbiter in front of one synchronous single-port data memory.
// Operands are captured in IDLE; a write runs ACCESS->DONE, a read ACCESS->WAIT->DONE.

module mem_arbiter_port #(
    parameter int reg_width = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 grant_set,
    input  logic                 grant_clr,
    input  logic                 done_set,
    input  logic                 rd_load,
    input  logic [reg_width-1:0] mem_q,
    output logic                 grant,
    output logic                 done,
    output logic [reg_width-1:0] rdata
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant <= 1'b0;
            done  <= 1'b0;
            rdata <= '0;
        end else begin
            if (grant_set)
                grant <= 1'b1;
            else if (grant_clr)
                grant <= 1'b0;
            done <= done_set;
            if (rd_load)
                rdata <= mem_q;
        end
    end

endmodule

module mem_arbiter #(
    parameter int reg_width  = 12,
    parameter int addr_width = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req1,
    input  logic                  req2,
    input  logic                  wren1,
    input  logic                  wren2,
    input  logic [reg_width-1:0]  addr1,
    input  logic [reg_width-1:0]  addr2,
    input  logic [reg_width-1:0]  wdata1,
    input  logic [reg_width-1:0]  wdata2,
    output logic                  grant1,
    output logic                  grant2,
    output logic                  done1,
    output logic                  done2,
    output logic [reg_width-1:0]  rdata1,
    output logic [reg_width-1:0]  rdata2,
    output logic [addr_width-1:0] mem_address,
    output logic [reg_width-1:0]  mem_data,
    output logic                  mem_wren,
    input  logic [reg_width-1:0]  mem_q,
    output logic                  busy
);

    localparam int NUM_CORES = 2;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    typedef struct packed {
        logic                 req;
        logic                 wren;
        logic [reg_width-1:0] addr;
        logic [reg_width-1:0] wdata;
    } core_req_t;

    state_t                                  state, state_nxt;
    core_req_t [NUM_CORES-1:0]               creq;
    logic                                    owner, last_served, pick;
    logic                                    launch, done_set, rd_load;
    logic [NUM_CORES-1:0]                    grant, done;
    logic [NUM_CORES-1:0][reg_width-1:0]     rdata;

    assign creq[0] = {req1, wren1, addr1, wdata1};
    assign creq[1] = {req2, wren2, addr2, wdata2};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Index 0 is core1, 1 is core2; on a tie the core not served last wins.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        pick      = 1'b0;
        done_set  = 1'b0;
        rd_load   = 1'b0;
        case (state)
            IDLE: begin
                if (creq[0].req || creq[1].req) begin
                    launch    = 1'b1;
                    pick      = (creq[0].req && creq[1].req) ? ~last_served : creq[1].req;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_wren) begin
                    state_nxt = DONE;
                    done_set  = 1'b1;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                state_nxt = DONE;
                done_set  = 1'b1;
                rd_load   = 1'b1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner       <= 1'b0;
            last_served <= 1'b1;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            if (launch) begin
                owner       <= pick;
                last_served <= pick;
                mem_address <= creq[pick].addr[addr_width-1:0];
                mem_data    <= creq[pick].wdata;
                mem_wren    <= creq[pick].wren;
            end else if (state == ACCESS) begin
                mem_wren <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_port
        mem_arbiter_port #(.reg_width(reg_width)) u_port (
            .clk       (clk),
            .reset     (reset),
            .grant_set (launch && (pick == 1'(g))),
            .grant_clr (state == DONE),
            .done_set  (done_set && (owner == 1'(g))),
            .rd_load   (rd_load && (owner == 1'(g))),
            .mem_q     (mem_q),
            .grant     (grant[g]),
            .done      (done[g]),
            .rdata     (rdata[g])
        );
    end

    assign grant1 = grant[0];
    assign grant2 = grant[1];
    assign done1  = done[0];
    assign done2  = done[1];
    assign rdata1 = rdata[0];
    assign rdata2 = rdata[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous memory and a done-driven scoreboard.

module tb_mem_arbiter;

    localparam int RW = 12;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req1 = 0, req2 = 0, wren1 = 0, wren2 = 0;
    logic [RW-1:0] addr1 = '0, addr2 = '0, wdata1 = '0, wdata2 = '0;
    logic          grant1, grant2, done1, done2, mem_wren, busy;
    logic [RW-1:0] rdata1, rdata2, mem_data, mem_q;
    logic [AW-1:0] mem_address;

    always #5 clk = ~clk;

    mem_arbiter #(.reg_width(RW), .addr_width(AW)) dut (
        .clk(clk), .reset(reset),
        .req1(req1), .req2(req2), .wren1(wren1), .wren2(wren2),
        .addr1(addr1), .addr2(addr2), .wdata1(wdata1), .wdata2(wdata2),
        .grant1(grant1), .grant2(grant2), .done1(done1), .done2(done2),
        .rdata1(rdata1), .rdata2(rdata2),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q), .busy(busy)
    );

    logic [RW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_wren) mem[mem_address] <= mem_data;
        mem_q <= mem[mem_address];
    end

    typedef struct {
        int            core;
        bit            rd;
        logic [RW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [RW-1:0] model [int];
    int            n_chk = 0;
    int            n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_grant1"}, 32'(grant1), 0);
        chk({tag, "_grant2"}, 32'(grant2), 0);
        chk({tag, "_done1"}, 32'(done1), 0);
        chk({tag, "_done2"}, 32'(done2), 0);
        chk({tag, "_mem_wren"}, 32'(mem_wren), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_mem_address"}, 32'(mem_address), 0);
        chk({tag, "_mem_data"}, 32'(mem_data), 0);
        chk({tag, "_rdata1"}, 32'(rdata1), 0);
        chk({tag, "_rdata2"}, 32'(rdata2), 0);
    endtask

    task automatic drive(input int core, input logic r, input logic w,
                         input logic [RW-1:0] a, input logic [RW-1:0] d);
        if (core == 1) begin req1 = r; wren1 = w; addr1 = a; wdata1 = d; end
        else           begin req2 = r; wren2 = w; addr2 = a; wdata2 = d; end
    endtask

    // Expected outcome enters the scoreboard when the request is driven.
    task automatic sb_push(input int core, input logic w, input logic [RW-1:0] a,
                           input logic [RW-1:0] d);
        exp_t e;
        e.core = core;
        e.rd   = !w;
        e.data = w ? '0 : model[int'(a)];
        sb.push_back(e);
        if (w) model[int'(a)] = d;
    endtask

    task automatic run_txn(input int core, input logic w, input logic [RW-1:0] a,
                           input logic [RW-1:0] d);
        int            n = 0, wcnt = 0, ogr = 0;
        logic          got = 1'b0;
        logic [RW-1:0] ord;
        ord = (core == 1) ? rdata2 : rdata1;
        sb_push(core, w, a, d);
        drive(core, 1'b1, w, a, d);
        while (!got && n < 20) begin
            @(posedge clk); #1; n++;
            if (mem_wren) begin
                wcnt++;
                chk("wr_addr", 32'(mem_address), 32'(a[AW-1:0]));
                chk("wr_data", 32'(mem_data), 32'(d));
            end
            if ((core == 1) ? grant2 : grant1) ogr++;
            got = (core == 1) ? done1 : done2;
        end
        chk("latency", n, w ? 2 : 3);
        chk("wren_cycles", wcnt, w ? 1 : 0);
        chk("other_grant", ogr, 0);
        chk("other_rdata", 32'((core == 1) ? rdata2 : rdata1), 32'(ord));
        drive(core, 1'b0, w, a, d);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("one_grant", 32'(grant1 & grant2), 0);
            chk("one_done", 32'(done1 & done2), 0);
            if (done1 || done2) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", {30'b0, done2, done1}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_core", done2 ? 2 : 1, mon_e.core);
                    if (mon_e.rd)
                        chk("rdata", 32'((mon_e.core == 1) ? rdata1 : rdata2), 32'(mon_e.data));
                end
            end
        end
    end

    initial begin
        int   n, t, nd;
        logic got, got1, got2, pg1, pg2;
        int   order[$];

        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        // Core1 write, then core2 reads it back.
        run_txn(1, 1'b1, 12'h005, 12'hABC);
        chk("mem5", 32'(mem[5]), 32'h0ABC);
        run_txn(2, 1'b0, 12'h005, 12'h000);
        chk("rdata2_read", 32'(rdata2), 32'h0ABC);
        chk("rdata1_kept", 32'(rdata1), 0);

        // Both cores hold requests: service alternates, core1 first.
        sb_push(1, 1'b1, 12'h020, 12'h111);
        sb_push(2, 1'b1, 12'h021, 12'h222);
        sb_push(1, 1'b1, 12'h020, 12'h111);
        sb_push(2, 1'b1, 12'h021, 12'h222);
        drive(1, 1'b1, 1'b1, 12'h020, 12'h111);
        drive(2, 1'b1, 1'b1, 12'h021, 12'h222);
        nd = 0; t = 0; pg1 = 0; pg2 = 0;
        while (nd < 4 && t < 60) begin
            @(posedge clk); #1; t++;
            if (grant1 && !pg1) order.push_back(1);
            if (grant2 && !pg2) order.push_back(2);
            pg1 = grant1; pg2 = grant2;
            if (done1 || done2) nd++;
        end
        drive(1, 1'b0, 1'b1, 12'h020, 12'h111);
        drive(2, 1'b0, 1'b1, 12'h021, 12'h222);
        chk("rr_dones", nd, 4);
        chk("rr_cycles", t, 11);
        for (int i = 0; i < 4; i++)
            chk("rr_order", (order.size() > i) ? order[i] : 0, (i % 2) + 1);
        repeat (2) @(posedge clk);
        #1;
        chk("rr_idle", 32'(busy), 0);
        chk("mem20", 32'(mem[12'h020]), 32'h111);
        chk("mem21", 32'(mem[12'h021]), 32'h222);

        // Core1 read: address changes and req drops during ACCESS.
        sb_push(1, 1'b0, 12'h005, 12'h000);
        drive(1, 1'b1, 1'b0, 12'h005, 12'h000);
        @(posedge clk); #1;
        chk("mid_grant1", 32'(grant1), 1);
        chk("mid_addr", 32'(mem_address), 32'h005);
        addr1 = 12'h020;
        req1  = 1'b0;
        n = 0; got = 0;
        while (!got && n < 10) begin
            @(posedge clk); #1; n++;
            got = done1;
        end
        chk("mid_latency", n, 2);
        chk("mid_rdata1", 32'(rdata1), 32'h0ABC);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_idle", 32'(busy), 0);

        // Reset lands in ACCESS of a write to 0x010.
        run_txn(2, 1'b1, 12'h010, 12'h123);
        drive(1, 1'b1, 1'b1, 12'h010, 12'h5A5);
        @(posedge clk); #1;
        chk("abort_wren_pre", 32'(mem_wren), 1);
        chk("abort_addr_pre", 32'(mem_address), 32'h010);
        reset = 1'b0;
        drive(1, 1'b0, 1'b0, 12'h000, 12'h000);
        #1;
        chk_zero_outputs("abort");
        repeat (2) @(posedge clk);
        #1;
        chk("mem10_kept", 32'(mem[12'h010]), 32'h123);
        chk("abort_no_done", {30'b0, done2, done1}, 0);

        // Release with both requesting: first edge grants core1 regardless of history.
        reset = 1'b1;
        sb_push(1, 1'b1, 12'h030, 12'h777);
        sb_push(2, 1'b0, 12'h030, 12'h000);
        drive(1, 1'b1, 1'b1, 12'h030, 12'h777);
        drive(2, 1'b1, 1'b0, 12'h030, 12'h000);
        @(posedge clk); #1;
        chk("rel_grant1", 32'(grant1), 1);
        chk("rel_grant2", 32'(grant2), 0);
        chk("rel_addr", 32'(mem_address), 32'h030);
        got1 = 0; got2 = 0; t = 0;
        while (!(got1 && got2) && t < 30) begin
            @(posedge clk); #1; t++;
            if (done1) begin got1 = 1; req1 = 1'b0; end
            if (done2) begin got2 = 1; req2 = 1'b0; end
        end
        chk("rel_both_done", {30'b0, got2, got1}, 3);
        chk("rel_rdata2", 32'(rdata2), 32'h777);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
